mem_addr_ctrl: RTL and testbench
================================

# mem_addr_ctrl

Parametrised address controller for the on-chip sample buffer, successor to the single write-pointer counter. It keeps a write pointer and a read pointer over a circular region of DEPTH words, tracks occupancy, and drives full/empty and sticky error flags. It sits between the capture FSM and the dual-port RAM, supplying write and read addresses and the buffer status used by the FSM for flow control.

## Interface
- AWIDTH, 4, address width in bits.
- DEPTH, 2**AWIDTH, buffer size in words; legal range 2..2**AWIDTH; need not be a power of two.
- WRAP_EN, 1, full-buffer write policy: 1 = overwrite oldest word; 0 = drop the write.

- clk_i  input  1  clock, all state updates on the rising edge.
- arstn_i  input  1  asynchronous, active-low reset.
- wren_i  input  1  write request for the current cycle.
- rden_i  input  1  read request for the current cycle.
- fsm_clr_i  input  1  synchronous clear from the capture FSM.
- wraddr_o  output  AWIDTH  RAM write address for the current cycle.
- rdaddr_o  output  AWIDTH  RAM read address for the current cycle.
- used_o  output  AWIDTH+1  number of valid words, 0..DEPTH.
- full_o  output  1  used_o == DEPTH.
- empty_o  output  1  used_o == 0.
- ovf_o  output  1  sticky: a write arrived while full.
- udf_o  output  1  sticky: a read arrived while empty.

## Operation
- Reset (arstn_i low, any time, no clock needed): wraddr_o = 0, rdaddr_o = 0, used_o = 0, empty_o = 1, full_o = 0, ovf_o = 0, udf_o = 0.
- Priority per cycle: fsm_clr_i, then read/write evaluation. A clear returns every output to its reset value on the next edge and ignores wren_i/rden_i that cycle.
- Read accepted iff rden_i && !empty_o. Accepted read: rdaddr_o advances by 1. Read while empty: nothing moves, udf_o set.
- Write accepted iff wren_i && (!full_o || WRAP_EN || read accepted in the same cycle). Accepted write: wraddr_o advances by 1.
- Full, WRAP_EN = 1, write without read: write accepted, rdaddr_o also advances (oldest word discarded), used_o stays DEPTH, ovf_o set.
- Full, WRAP_EN = 0, write without read: write dropped, pointers and used_o unchanged, ovf_o set.
- Full, simultaneous read and write: both accepted, used_o stays DEPTH, ovf_o not set.
- Empty, simultaneous read and write: read rejected (udf_o set), write accepted, used_o becomes 1.
- Otherwise used_o: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Pointer wrap: a pointer at DEPTH-1 advances to 0, never to DEPTH..2**AWIDTH-1.
- ovf_o and udf_o stay set until fsm_clr_i or reset.
- full_o and empty_o are registered and always consistent with used_o in the same cycle.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- wraddr_o/rdaddr_o are the addresses for the current cycle; the RAM writes at wraddr_o in the cycle wren_i is high. Pointer advance is visible one cycle after the accepted strobe.
- used_o, full_o, empty_o, ovf_o, udf_o update one cycle after the causing strobe.
- Reset deassertion is synchronised by the top-level reset bridge; the block requires no special first-cycle behaviour.
- Reset mid-operation: all state cleared immediately on arstn_i low, independent of the clock.

## Test plan
- Reset: hold arstn_i low with random strobes, release -> wraddr_o = 0, rdaddr_o = 0, used_o = 0, empty_o = 1, both flags 0; assert arstn_i low mid-stream between edges -> outputs zero before the next edge.
- Fill and wrap, AWIDTH=3, DEPTH=6: 6 writes -> wraddr_o 0,1,..,5,0, full_o = 1, used_o = 6; 6 reads -> rdaddr_o wraps 5->0, empty_o = 1.
- Overflow, WRAP_EN=1, DEPTH=6: 8 writes -> used_o = 6, wraddr_o = 2, rdaddr_o = 2, ovf_o = 1. Same with WRAP_EN=0 -> wraddr_o = 0, rdaddr_o = 0, used_o = 6, ovf_o = 1.
- Underflow: read when empty -> rdaddr_o unchanged, udf_o = 1; read+write when empty -> used_o = 1, wraddr_o = 1, rdaddr_o = 0, udf_o = 1.
- Simultaneous at full, WRAP_EN=0: read+write -> both pointers +1, used_o = 6, ovf_o = 0.
- Clear: with used_o = 4 and ovf_o = 1, pulse fsm_clr_i together with wren_i -> next cycle all outputs at reset values, write ignored.

Source files
------------

// File: rtl/mem_addr_ctrl.sv
// Address controller for the circular sample buffer: write/read pointers over
// DEPTH words, occupancy count, full/empty status and sticky over/underflow flags.
module mem_addr_ctrl #(
    parameter int AWIDTH  = 4,
    parameter int DEPTH   = 2**AWIDTH,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              wren_i,
    input  logic              rden_i,
    input  logic              fsm_clr_i,
    output logic [AWIDTH-1:0] wraddr_o,
    output logic [AWIDTH-1:0] rdaddr_o,
    output logic [AWIDTH:0]   used_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   DEPTH_W  = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AWIDTH:0]   used_q, used_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_acc, wr_acc, rd_adv;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths never address past the buffer.
    function automatic logic [AWIDTH-1:0] next_ptr(input logic [AWIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AWIDTH'(1);
    endfunction

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        used_d  = used_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        rd_acc  = rden_i && !empty_q;
        wr_acc  = wren_i && (!full_q || WRAP_EN || rd_acc);
        // An overwriting write at full also retires the oldest word.
        rd_adv  = rd_acc || (wren_i && full_q && WRAP_EN && !rd_acc);

        if (fsm_clr_i) begin
            wr_d   = '0;
            rd_d   = '0;
            used_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (rden_i && empty_q)
                udf_d = 1'b1;
            if (wren_i && full_q && !rd_acc)
                ovf_d = 1'b1;
            if (wr_acc)
                wr_d = next_ptr(wr_q);
            if (rd_adv)
                rd_d = next_ptr(rd_q);
            if (wr_acc && !rd_adv)
                used_d = used_q + (AWIDTH + 1)'(1);
            else if (rd_adv && !wr_acc)
                used_d = used_q - (AWIDTH + 1)'(1);
        end

        full_d  = (used_d == DEPTH_W);
        empty_d = (used_d == '0);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            used_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            used_q  <= used_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wraddr_o = wr_q;
    assign rdaddr_o = rd_q;
    assign used_o   = used_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule

// File: tb/tb_mem_addr_ctrl.sv
// Bench for mem_addr_ctrl: two instances (overwrite and drop policy, DEPTH=6)
// driven by shared strobes and checked against a counter-based buffer model.
module tb_mem_addr_ctrl;
    localparam int AW  = 3;
    localparam int DEP = 6;
    localparam int OW  = 14;   // {wr[3], rd[3], used[4], full, empty, ovf, udf}

    logic clk = 1'b0, arstn = 1'b0, wren = 1'b0, rden = 1'b0, clr = 1'b0;

    logic [AW-1:0] wr_w, rd_w, wr_d, rd_d;
    logic [AW:0]   used_w, used_d;
    logic          full_w, empty_w, ovf_w, udf_w;
    logic          full_d, empty_d, ovf_d, udf_d;

    mem_addr_ctrl #(.AWIDTH(AW), .DEPTH(DEP), .WRAP_EN(1'b1)) u_wrap (
        .clk_i(clk), .arstn_i(arstn), .wren_i(wren), .rden_i(rden), .fsm_clr_i(clr),
        .wraddr_o(wr_w), .rdaddr_o(rd_w), .used_o(used_w), .full_o(full_w),
        .empty_o(empty_w), .ovf_o(ovf_w), .udf_o(udf_w));

    mem_addr_ctrl #(.AWIDTH(AW), .DEPTH(DEP), .WRAP_EN(1'b0)) u_drop (
        .clk_i(clk), .arstn_i(arstn), .wren_i(wren), .rden_i(rden), .fsm_clr_i(clr),
        .wraddr_o(wr_d), .rdaddr_o(rd_d), .used_o(used_d), .full_o(full_d),
        .empty_o(empty_d), .ovf_o(ovf_d), .udf_o(udf_d));

    // clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [OW-1:0] exp_q[$];

    // Model: totals of accepted writes/reads; pointers are totals mod DEPTH.
    int   m_wc[2];
    int   m_rc[2];
    logic m_ovf[2];
    logic m_udf[2];

    function automatic logic [OW-1:0] pack(input int wr, input int rd, input int used,
                                           input logic ovf, input logic udf);
        return {3'(wr), 3'(rd), 4'(used), used == DEP, used == 0, ovf, udf};
    endfunction

    localparam logic [OW-1:0] RST_VAL = 14'h0004;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_wc[p] = 0; m_rc[p] = 0; m_ovf[p] = 1'b0; m_udf[p] = 1'b0;
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic c);
        for (int p = 0; p < 2; p++) begin
            int  used;
            bit  rd_ok;
            used  = m_wc[p] - m_rc[p];
            rd_ok = r && (used > 0);
            if (c) begin
                m_wc[p] = 0; m_rc[p] = 0; m_ovf[p] = 1'b0; m_udf[p] = 1'b0;
            end else begin
                if (r && used == 0) m_udf[p] = 1'b1;
                if (w) begin
                    if (used == DEP && !rd_ok) begin
                        m_ovf[p] = 1'b1;
                        if (p == 0) begin
                            m_wc[p]++;
                            m_rc[p]++;
                        end
                    end else begin
                        m_wc[p]++;
                    end
                end
                if (rd_ok) m_rc[p]++;
            end
        end
    endtask

    function automatic logic [OW-1:0] model_out(input int p);
        return pack(m_wc[p] % DEP, m_rc[p] % DEP, m_wc[p] - m_rc[p], m_ovf[p], m_udf[p]);
    endfunction

    function automatic logic [OW-1:0] act_out(input int p);
        if (p == 0) return {wr_w, rd_w, used_w, full_w, empty_w, ovf_w, udf_w};
        return {wr_d, rd_d, used_d, full_d, empty_d, ovf_d, udf_d};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got wr=%0d rd=%0d used=%0d f=%b e=%b o=%b u=%b, expected wr=%0d rd=%0d used=%0d f=%b e=%b o=%b u=%b",
                     name, $time, act[13:11], act[10:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[13:11], exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // scoreboard
    task automatic sb_push();
        exp_q.push_back(model_out(0));
        exp_q.push_back(model_out(1));
    endtask

    task automatic sb_check(input string name);
        for (int p = 0; p < 2; p++) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: scoreboard queue empty", name);
            end else begin
                check({name, (p == 0) ? "_wrap" : "_drop"}, act_out(p), exp_q.pop_front());
            end
        end
    endtask

    // driver: called at posedge+1, samples at next posedge+1
    task automatic cycle(input logic w, input logic r, input logic c, input string name);
        wren = w; rden = r; clr = c;
        model_step(w, r, c);
        sb_push();
        @(posedge clk);
        #1;
        sb_check(name);
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wren = 1'($urandom_range(0, 1));
            rden = 1'($urandom_range(0, 1));
            clr  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        model_reset();
        wren = 1'b0; rden = 1'b0; clr = 1'b0;
        arstn = 1'b1;
        check("reset_wrap", act_out(0), RST_VAL);
        check("reset_drop", act_out(1), RST_VAL);
    endtask

    typedef struct packed {
        logic       w;
        logic       r;
        logic [2:0] ewr;
        logic [2:0] erd;
        logic [3:0] eused;
        logic       eovf;
        logic       eudf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // fill, drain with wrap, then underflow and read+write while empty
        tbl[0]  = '{1'b1, 1'b0, 3'd1, 3'd0, 4'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd2, 3'd0, 4'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd3, 3'd0, 4'd3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd4, 3'd0, 4'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd5, 3'd0, 4'd5, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 3'd0, 4'd6, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 3'd1, 4'd5, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 3'd2, 4'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 3'd3, 4'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 3'd4, 4'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 3'd5, 4'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 3'd1, 3'd0, 4'd1, 1'b0, 1'b1};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            logic [OW-1:0] e;
            cycle(tbl[i].w, tbl[i].r, 1'b0, "tbl_model");
            e = pack(tbl[i].ewr, tbl[i].erd, tbl[i].eused, tbl[i].eovf, tbl[i].eudf);
            check($sformatf("tbl%0d_wrap", i), act_out(0), e);
            check($sformatf("tbl%0d_drop", i), act_out(1), e);
        end

        cycle(1'b0, 1'b0, 1'b1, "clr1");
        check("clr1_wrap", act_out(0), RST_VAL);
        check("clr1_drop", act_out(1), RST_VAL);

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, "ovf_seq");
        check("ovf_wrap", act_out(0), pack(2, 2, 6, 1'b1, 1'b0));
        check("ovf_drop", act_out(1), pack(0, 0, 6, 1'b1, 1'b0));

        cycle(1'b0, 1'b1, 1'b0, "rd_after_ovf");
        cycle(1'b0, 1'b1, 1'b0, "rd_after_ovf");
        check("used4_wrap", act_out(0), pack(2, 4, 4, 1'b1, 1'b0));
        check("used4_drop", act_out(1), pack(0, 2, 4, 1'b1, 1'b0));
        cycle(1'b1, 1'b0, 1'b1, "clr_w");
        check("clr_w_wrap", act_out(0), RST_VAL);
        check("clr_w_drop", act_out(1), RST_VAL);

        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, "fill");
        cycle(1'b1, 1'b1, 1'b0, "full_rw");
        check("full_rw_wrap", act_out(0), pack(1, 1, 6, 1'b0, 1'b0));
        check("full_rw_drop", act_out(1), pack(1, 1, 6, 1'b0, 1'b0));
        cycle(1'b0, 1'b0, 1'b1, "clr2");

        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            if (i == 300) begin
                #2;
                arstn = 1'b0;
                #1;
                check("async_rst_wrap", act_out(0), RST_VAL);
                check("async_rst_drop", act_out(1), RST_VAL);
                model_reset();
                wren = 1'($urandom_range(0, 1));
                rden = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                check("rst_hold_wrap", act_out(0), RST_VAL);
                check("rst_hold_drop", act_out(1), RST_VAL);
                arstn = 1'b1;
            end
            cycle(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
                  1'($urandom_range(0, 39) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
